// File: rtl/periph_router_pkg.sv
// ---------------------------------------------------------------------------
// periph_router_pkg
// Shared constants and types for the peripheral router.
//   MAX_SLV       : largest number of slave ports the router can be built with
//   DEF_SLV_BASE  : default base address of each slave window (256 MB apart)
//   DEF_SLV_MASK  : default compare mask of each slave window (top nibble)
//   tgt_idx_t     : target index; values 0..N_SLV-1 name a slave, N_SLV names
//                   the decode-error pseudo-target
// ---------------------------------------------------------------------------
package periph_router_pkg;

    localparam int MAX_SLV = 8;

    // Slave i lives at i * 256 MB; only the first N_SLV entries are used
    localparam logic [MAX_SLV-1:0][31:0] DEF_SLV_BASE = {
        32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
        32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };

    localparam logic [MAX_SLV-1:0][31:0] DEF_SLV_MASK = {MAX_SLV{32'hF000_0000}};

    // Four bits so that index MAX_SLV (decode error with 8 slaves) still fits
    typedef logic [3:0] tgt_idx_t;

endpackage

// File: rtl/periph_router_decode.sv
// ---------------------------------------------------------------------------
// periph_router_decode
// Combinational address decoder. The lowest-numbered matching window wins.
//   i_addr   : request address
//   o_onehot : one-hot select of the matching slave (all zero on a miss)
//   o_idx    : index of the matching slave, N_SLV on a miss
//   o_miss   : no window matched (decode error)
// ---------------------------------------------------------------------------
module periph_router_decode
    import periph_router_pkg::*;
#(
    parameter int                        N_SLV    = 4,
    parameter logic [MAX_SLV-1:0][31:0]  SLV_BASE = DEF_SLV_BASE,
    parameter logic [MAX_SLV-1:0][31:0]  SLV_MASK = DEF_SLV_MASK
) (
    input  logic [31:0]      i_addr,
    output logic [N_SLV-1:0] o_onehot,
    output tgt_idx_t         o_idx,
    output logic             o_miss
);

    logic [N_SLV-1:0] w_hit;

    // Raw window hits; several windows may overlap
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_SLV; i++) begin
            w_hit[i] = ((i_addr & SLV_MASK[i]) == SLV_BASE[i]);
        end
    end

    // Walk from the top down so the lowest matching index overwrites the rest
    always_comb begin
        o_onehot = '0;
        o_idx    = tgt_idx_t'(N_SLV);
        o_miss   = 1'b1;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = tgt_idx_t'(i);
                o_miss      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/periph_router.sv
// ---------------------------------------------------------------------------
// periph_router
// Routes one master request/grant/rvalid port to N_SLV slave ports by address
// window, keeping responses in order by allowing only one target in flight.
// Requests to unmapped addresses are granted at once and answered one cycle
// later with an error response.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   mem_*               : master side (req/gnt, addr/we/be/wdata, rvalid/err/rdata)
//   slv_*               : slave side, req/gnt/rvalid/err/rdata per slave,
//                         addr/we/be/wdata shared by all slaves
//   proto_err_o         : sticky, a slave answered when nothing was expected of it
//   timeout_o           : sticky, the response watchdog fired
//
// Configuration
//   ROUTER_TIMEOUT_EN   : define to build the response watchdog; without it
//                         the router waits for a response indefinitely
// ---------------------------------------------------------------------------
module periph_router
    import periph_router_pkg::*;
#(
    parameter int                        MEM_W       = 32,
    parameter int                        N_SLV       = 4,
    parameter logic [MAX_SLV-1:0][31:0]  SLV_BASE    = DEF_SLV_BASE,
    parameter logic [MAX_SLV-1:0][31:0]  SLV_MASK    = DEF_SLV_MASK,
    parameter int                        MAX_OUTST   = 2,
    parameter int                        TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_req_i,
    output logic                          mem_gnt_o,
    input  logic [31:0]                   mem_addr_i,
    input  logic                          mem_we_i,
    input  logic [MEM_W/8-1:0]            mem_be_i,
    input  logic [MEM_W-1:0]              mem_wdata_i,
    output logic                          mem_rvalid_o,
    output logic                          mem_err_o,
    output logic [MEM_W-1:0]              mem_rdata_o,
    output logic [N_SLV-1:0]              slv_req_o,
    input  logic [N_SLV-1:0]              slv_gnt_i,
    output logic [31:0]                   slv_addr_o,
    output logic                          slv_we_o,
    output logic [MEM_W/8-1:0]            slv_be_o,
    output logic [MEM_W-1:0]              slv_wdata_o,
    input  logic [N_SLV-1:0]              slv_rvalid_i,
    input  logic [N_SLV-1:0]              slv_err_i,
    input  logic [N_SLV-1:0][MEM_W-1:0]   slv_rdata_i,
    output logic                          proto_err_o,
    output logic                          timeout_o
);

    typedef logic [3:0] cnt_t;
    localparam cnt_t MAX_CNT = cnt_t'(MAX_OUTST);

    logic [N_SLV-1:0] w_tgt_onehot;
    tgt_idx_t         w_tgt;
    logic             w_miss;

    cnt_t             r_outst_cnt;
    tgt_idx_t         r_cur_tgt;
    logic             r_decerr_pend;
    logic             r_proto_err;

    logic             w_busy;
    logic             w_stall;
    logic             w_accept;
    logic [N_SLV-1:0] w_cur_onehot;
    logic [N_SLV-1:0] w_stray;
    logic             w_slv_rvalid;
    logic             w_slv_err;
    logic [MEM_W-1:0] w_slv_rdata;
    logic             w_timeout_fire;
    logic             w_rsp;

    periph_router_decode #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .i_addr   (mem_addr_i),
        .o_onehot (w_tgt_onehot),
        .o_idx    (w_tgt),
        .o_miss   (w_miss)
    );

    assign w_busy  = (r_outst_cnt != '0);

    // Switching target while anything is in flight could reorder responses
    assign w_stall = (r_outst_cnt == MAX_CNT) || (w_busy && (w_tgt != r_cur_tgt));

    // Request path: pass-through of the command, one request line raised.
    // Everything is held at zero while reset is asserted.
    always_comb begin
        slv_req_o   = '0;
        slv_addr_o  = '0;
        slv_we_o    = 1'b0;
        slv_be_o    = '0;
        slv_wdata_o = '0;
        mem_gnt_o   = 1'b0;
        if (!rst) begin
            slv_addr_o  = mem_addr_i;
            slv_we_o    = mem_we_i;
            slv_be_o    = mem_be_i;
            slv_wdata_o = mem_wdata_i;
            if (mem_req_i && !w_stall) begin
                slv_req_o = w_tgt_onehot;
            end
            if (!w_stall) begin
                mem_gnt_o = w_miss ? 1'b1 : |(slv_gnt_i & w_tgt_onehot);
            end
        end
    end

    assign w_accept = mem_req_i && mem_gnt_o;

    // Which slave may answer right now; nobody when idle or waiting on DECERR
    always_comb begin
        w_cur_onehot = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (w_busy && (r_cur_tgt == tgt_idx_t'(i))) begin
                w_cur_onehot[i] = 1'b1;
            end
        end
    end

    // Mux the current slave's error and data onto the response path
    always_comb begin
        w_slv_err   = 1'b0;
        w_slv_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (w_cur_onehot[i]) begin
                w_slv_err   = slv_err_i[i];
                w_slv_rdata = slv_rdata_i[i];
            end
        end
    end

    assign w_slv_rvalid = |(slv_rvalid_i & w_cur_onehot);
    assign w_stray      = slv_rvalid_i & ~w_cur_onehot;

    // Master response: real slave data first, otherwise a synthesized error
    // for a decode miss or a watchdog expiry; zero whenever nothing is sent
    always_comb begin
        mem_rvalid_o = 1'b0;
        mem_err_o    = 1'b0;
        mem_rdata_o  = '0;
        if (w_slv_rvalid) begin
            mem_rvalid_o = 1'b1;
            mem_err_o    = w_slv_err;
            mem_rdata_o  = w_slv_rdata;
        end else if (r_decerr_pend || w_timeout_fire) begin
            mem_rvalid_o = 1'b1;
            mem_err_o    = 1'b1;
        end
    end

    assign w_rsp = mem_rvalid_o;

    // Outstanding bookkeeping: an accept and a response in the same cycle
    // cancel out. A decode miss is answered on the very next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outst_cnt   <= '0;
            r_cur_tgt     <= '0;
            r_decerr_pend <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_tgt <= w_tgt;
            end
            if (w_accept && !w_rsp) begin
                r_outst_cnt <= r_outst_cnt + cnt_t'(1);
            end else if (!w_accept && w_rsp) begin
                r_outst_cnt <= r_outst_cnt - cnt_t'(1);
            end
            r_decerr_pend <= w_accept && w_miss;
            if (|w_stray) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err_o = r_proto_err;

`ifdef ROUTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    typedef logic [WD_W-1:0] wd_t;
    localparam wd_t WD_LAST = wd_t'(TIMEOUT_CYC - 1);

    wd_t  r_wd_cnt;
    logic r_timeout;

    // The counter holds the number of waiting cycles already elapsed, so the
    // error goes out during the TIMEOUT_CYC-th waiting cycle after accept
    assign w_timeout_fire = w_busy && !w_slv_rvalid && !r_decerr_pend && (r_wd_cnt == WD_LAST);

    // Watchdog: counts cycles spent waiting, restarts on every response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_busy || w_rsp) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + wd_t'(1);
            end
            if (w_timeout_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_timeout_fire = 1'b0;
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_periph_router.sv
// ---------------------------------------------------------------------------
// tb_periph_router
// Self-checking bench for periph_router with the default four-slave map.
// Directed decode vectors, hand-written multi-cycle sequences, then a random
// run compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_periph_router;

   localparam int MEM_W     = 32;
   localparam int N         = 4;
   localparam int MAX_OUTST = 2;
   localparam int TIMEOUT   = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   memReq;
   logic                   memGnt;
   logic [31:0]            memAddr;
   logic                   memWe;
   logic [3:0]             memBe;
   logic [31:0]            memWdata;
   logic                   memRvalid;
   logic                   memErr;
   logic [31:0]            memRdata;
   logic [N-1:0]           slvReq;
   logic [N-1:0]           slvGnt;
   logic [31:0]            slvAddr;
   logic                   slvWe;
   logic [3:0]             slvBe;
   logic [31:0]            slvWdata;
   logic [N-1:0]           slvRvalid;
   logic [N-1:0]           slvErr;
   logic [N-1:0][31:0]     slvRdata;
   logic                   protoErr;
   logic                   timeoutHit;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic [31:0] addr;
      logic        req;
      logic [3:0]  gnt;
      logic        expGnt;
      logic [3:0]  expReq;
   } vec_t;

   vec_t vecs[8];

   // Reference address map, written straight from the default windows
   logic [31:0] refBase[N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
   logic [31:0] refMask    = 32'hF000_0000;

   int refQ[$];
   bit refProto;
   int slvPend[N];
   int slvWait[N];

   always #5 clk = ~clk;

   periph_router #(
      .MEM_W       (MEM_W),
      .N_SLV       (N),
      .MAX_OUTST   (MAX_OUTST),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req_i    (memReq),
      .mem_gnt_o    (memGnt),
      .mem_addr_i   (memAddr),
      .mem_we_i     (memWe),
      .mem_be_i     (memBe),
      .mem_wdata_i  (memWdata),
      .mem_rvalid_o (memRvalid),
      .mem_err_o    (memErr),
      .mem_rdata_o  (memRdata),
      .slv_req_o    (slvReq),
      .slv_gnt_i    (slvGnt),
      .slv_addr_o   (slvAddr),
      .slv_we_o     (slvWe),
      .slv_be_o     (slvBe),
      .slv_wdata_o  (slvWdata),
      .slv_rvalid_i (slvRvalid),
      .slv_err_i    (slvErr),
      .slv_rdata_i  (slvRdata),
      .proto_err_o  (protoErr),
      .timeout_o    (timeoutHit)
   );

   // One comparison; every mismatch gets its own line
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive master request and slave side, then let combinational paths settle
   task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic [3:0] gnt,
                                input logic [3:0] rvalid, input logic [31:0] rdata);
      memReq    = req;
      memAddr   = addr;
      memWe     = 1'b0;
      memBe     = 4'hF;
      memWdata  = 32'h0;
      slvGnt    = gnt;
      slvRvalid = rvalid;
      slvErr    = '0;
      for (int j = 0; j < N; j++) slvRdata[j] = rdata;
      #1;
   endtask

   // Assert reset with a live request on the bus and check everything is quiet
   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b1, 32'h1000_0000, 4'hF, 4'h0, 32'h0);
      checkOutput("rst_gnt", memGnt, 0);
      checkOutput("rst_slvreq", slvReq, 0);
      checkOutput("rst_slvaddr", slvAddr, 0);
      checkOutput("rst_rvalid", memRvalid, 0);
      checkOutput("rst_proto", protoErr, 0);
      checkOutput("rst_timeout", timeoutHit, 0);
      step();
      step();
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
   endtask

   function automatic int refTarget(input logic [31:0] a);
      for (int i = 0; i < N; i++) begin
         if ((a & refMask) == refBase[i]) return i;
      end
      return N;
   endfunction

   initial begin
      logic [31:0] addr;
      int          tgt;
      int          nib;
      bit          stall;
      bit          expGnt;
      logic [3:0]  expReq;
      bit          expRv;
      bit          expErr;
      logic [31:0] expData;

      vecs[0] = '{32'h0000_0100, 1'b1, 4'b0001, 1'b1, 4'b0001};
      vecs[1] = '{32'h1000_0010, 1'b1, 4'b0000, 1'b0, 4'b0010};
      vecs[2] = '{32'h2ABC_0000, 1'b1, 4'b0100, 1'b1, 4'b0100};
      vecs[3] = '{32'h3FFF_FFFC, 1'b1, 4'b0111, 1'b0, 4'b1000};
      vecs[4] = '{32'h8000_0000, 1'b1, 4'b1111, 1'b1, 4'b0000};
      vecs[5] = '{32'hF000_0000, 1'b0, 4'b0000, 1'b1, 4'b0000};
      vecs[6] = '{32'h1000_0000, 1'b0, 4'b0010, 1'b1, 4'b0000};
      vecs[7] = '{32'h4000_0000, 1'b1, 4'b0000, 1'b1, 4'b0000};

      $display("[TB] reset");
      doReset();

      // Decode table, applied while idle; request dropped before each edge
      $display("[TB] decode vectors");
      for (int v = 0; v < 8; v++) begin
         step();
         applyStimulus(vecs[v].req, vecs[v].addr, vecs[v].gnt, 4'h0, 32'h0);
         checkOutput($sformatf("vec%0d_gnt", v), memGnt, vecs[v].expGnt);
         checkOutput($sformatf("vec%0d_slvreq", v), slvReq, vecs[v].expReq);
         checkOutput($sformatf("vec%0d_addr", v), slvAddr, vecs[v].addr);
         applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
      end

      // Single read to slave 1, response two cycles later
      $display("[TB] single read");
      step(); applyStimulus(1'b1, 32'h1000_0010, 4'b0010, 4'h0, 32'h0);
      checkOutput("rd_gnt", memGnt, 1);
      checkOutput("rd_slvreq", slvReq, 4'b0010);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
      checkOutput("rd_wait", memRvalid, 0);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'b0010, 32'hDEAD_BEEF);
      checkOutput("rd_rvalid", memRvalid, 1);
      checkOutput("rd_rdata", memRdata, 32'hDEAD_BEEF);
      checkOutput("rd_err", memErr, 0);
      step(); applyStimulus(1'b0, 32'h2000_0000, 4'b0100, 4'h0, 32'h0);
      checkOutput("rd_idle_again", memGnt, 1);
      checkOutput("rd_rdata_zero", memRdata, 0);

      // Two reads to slave 0, then slave 2 must wait for both responses
      $display("[TB] in-order stall");
      step(); applyStimulus(1'b1, 32'h0000_0004, 4'b0001, 4'h0, 32'h0);
      checkOutput("io_gnt0", memGnt, 1);
      step(); applyStimulus(1'b1, 32'h0000_0008, 4'b0001, 4'h0, 32'h0);
      checkOutput("io_gnt1", memGnt, 1);
      step(); applyStimulus(1'b1, 32'h2000_0000, 4'b0100, 4'h0, 32'h0);
      checkOutput("io_stall_gnt", memGnt, 0);
      checkOutput("io_stall_req", slvReq, 0);
      step(); applyStimulus(1'b1, 32'h2000_0000, 4'b0100, 4'b0001, 32'h0000_0111);
      checkOutput("io_rsp0", memRdata, 32'h0000_0111);
      checkOutput("io_rsp0_gnt", memGnt, 0);
      step(); applyStimulus(1'b1, 32'h2000_0000, 4'b0100, 4'b0001, 32'h0000_0222);
      checkOutput("io_rsp1", memRdata, 32'h0000_0222);
      checkOutput("io_rsp1_gnt", memGnt, 0);
      step(); applyStimulus(1'b1, 32'h2000_0000, 4'b0100, 4'h0, 32'h0);
      checkOutput("io_s2_gnt", memGnt, 1);
      checkOutput("io_s2_req", slvReq, 4'b0100);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'b0100, 32'h0000_0333);
      checkOutput("io_s2_rsp", memRdata, 32'h0000_0333);

      // Unmapped read, then a burst of three back-to-back unmapped reads
      $display("[TB] decode error");
      step(); applyStimulus(1'b1, 32'h8000_0000, 4'h0, 4'h0, 32'h0);
      checkOutput("de_gnt", memGnt, 1);
      checkOutput("de_slvreq", slvReq, 0);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'hFFFF_FFFF);
      checkOutput("de_rvalid", memRvalid, 1);
      checkOutput("de_err", memErr, 1);
      checkOutput("de_rdata", memRdata, 0);
      step(); applyStimulus(1'b1, 32'h9000_0000, 4'h0, 4'h0, 32'h0);
      checkOutput("de_quiet", memRvalid, 0);
      for (int k = 0; k < 2; k++) begin
         step(); applyStimulus(1'b1, 32'hA000_0000, 4'h0, 4'h0, 32'h0);
         checkOutput($sformatf("de_b2b_gnt%0d", k), memGnt, 1);
         checkOutput($sformatf("de_b2b_rv%0d", k), memRvalid, 1);
      end
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
      checkOutput("de_b2b_last", memRvalid, 1);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
      checkOutput("de_b2b_done", memRvalid, 0);

      // Saturate slave 3, then accept and respond in the same cycle
      $display("[TB] max outstanding");
      step(); applyStimulus(1'b1, 32'h3000_0000, 4'b1000, 4'h0, 32'h0);
      checkOutput("mo_gnt_a", memGnt, 1);
      step(); applyStimulus(1'b1, 32'h3000_0004, 4'b1000, 4'h0, 32'h0);
      checkOutput("mo_gnt_b", memGnt, 1);
      step(); applyStimulus(1'b1, 32'h3000_0008, 4'b1000, 4'h0, 32'h0);
      checkOutput("mo_full", memGnt, 0);
      step(); applyStimulus(1'b1, 32'h3000_0008, 4'b1000, 4'b1000, 32'h0000_0A01);
      checkOutput("mo_full_rsp", memGnt, 0);
      checkOutput("mo_rsp_a", memRvalid, 1);
      step(); applyStimulus(1'b1, 32'h3000_0008, 4'b1000, 4'b1000, 32'h0000_0A02);
      checkOutput("mo_both_gnt", memGnt, 1);
      checkOutput("mo_both_rv", memRvalid, 1);
      step(); applyStimulus(1'b1, 32'h3000_000C, 4'b1000, 4'h0, 32'h0);
      checkOutput("mo_refill", memGnt, 1);
      step(); applyStimulus(1'b1, 32'h3000_0010, 4'b1000, 4'h0, 32'h0);
      checkOutput("mo_full_again", memGnt, 0);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'b1000, 32'h0);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'b1000, 32'h0);
      step(); applyStimulus(1'b0, 32'h0000_0000, 4'b0001, 4'h0, 32'h0);
      checkOutput("mo_drained", memGnt, 1);
      checkOutput("mo_proto_clean", protoErr, 0);

      // Stray response while idle
      $display("[TB] stray response");
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'b0100, 32'h5555_5555);
      checkOutput("st_rvalid", memRvalid, 0);
      checkOutput("st_rdata", memRdata, 0);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
      checkOutput("st_proto", protoErr, 1);
      step(); step();
      checkOutput("st_sticky", protoErr, 1);
      doReset();

      // Reset with a request in flight; the late answer is a stray
      $display("[TB] reset mid-flight");
      step(); applyStimulus(1'b1, 32'h1000_0000, 4'b0010, 4'h0, 32'h0);
      checkOutput("rm_gnt", memGnt, 1);
      step();
      doReset();
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'b0010, 32'h1234_5678);
      checkOutput("rm_late_rv", memRvalid, 0);
      step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
      checkOutput("rm_proto", protoErr, 1);
      doReset();

`ifdef ROUTER_TIMEOUT_EN
      // Slave 0 never answers; the watchdog answers on its behalf
      $display("[TB] watchdog");
      step(); applyStimulus(1'b1, 32'h0000_0040, 4'b0001, 4'h0, 32'h0);
      checkOutput("wd_gnt", memGnt, 1);
      for (int k = 1; k <= TIMEOUT; k++) begin
         step(); applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
         checkOutput($sformatf("wd_cyc%0d", k), memRvalid, (k == TIMEOUT));
      end
      checkOutput("wd_err", memErr, 1);
      checkOutput("wd_rdata", memRdata, 0);
      step();
      checkOutput("wd_flag", timeoutHit, 1);
      checkOutput("wd_rv_once", memRvalid, 0);
      applyStimulus(1'b1, 32'h0000_0040, 4'b0001, 4'h0, 32'h0);
      step();
      doReset();
`else
      step();
      checkOutput("wd_absent", timeoutHit, 0);
`endif

      // Random traffic against the queue model
      $display("[TB] random traffic");
      refQ.delete();
      refProto = 0;
      for (int j = 0; j < N; j++) begin
         slvPend[j] = 0;
         slvWait[j] = 0;
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         step();
         nib = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
         addr = {nib[3:0], 28'($urandom)};
         memReq   = ($urandom_range(0, 3) != 0);
         memAddr  = addr;
         memWe    = 1'($urandom);
         memBe    = 4'($urandom);
         memWdata = $urandom;
         slvGnt   = 4'($urandom);
         for (int j = 0; j < N; j++) begin
            slvRvalid[j] = (slvPend[j] > 0) && (slvWait[j] >= 6 || $urandom_range(0, 1) == 1);
            slvErr[j]    = ($urandom_range(0, 7) == 0);
            slvRdata[j]  = $urandom;
         end
         #1;

         tgt    = refTarget(addr);
         stall  = (refQ.size() >= MAX_OUTST) || (refQ.size() > 0 && refQ[$] != tgt);
         expGnt = !stall && ((tgt == N) ? 1'b1 : slvGnt[tgt]);
         expReq = (memReq && !stall && tgt < N) ? 4'(1 << tgt) : 4'h0;
         expRv  = 0;
         expErr = 0;
         expData = 32'h0;
         if (refQ.size() > 0) begin
            if (refQ[0] == N) begin
               expRv  = 1;
               expErr = 1;
            end else if (slvRvalid[refQ[0]]) begin
               expRv   = 1;
               expErr  = slvErr[refQ[0]];
               expData = slvRdata[refQ[0]];
            end
         end

         checkOutput("rnd_gnt", memGnt, expGnt);
         checkOutput("rnd_slvreq", slvReq, expReq);
         checkOutput("rnd_rvalid", memRvalid, expRv);
         checkOutput("rnd_err", memErr, expErr);
         checkOutput("rnd_rdata", memRdata, expData);
         checkOutput("rnd_cmd", {slvWe, slvBe, slvAddr}, {memWe, memBe, addr});
         checkOutput("rnd_wdata", slvWdata, memWdata);
         checkOutput("rnd_proto", protoErr, refProto);
         checkOutput("rnd_timeout", timeoutHit, 0);

         for (int j = 0; j < N; j++) begin
            if (slvRvalid[j] && !(refQ.size() > 0 && refQ[0] == j)) refProto = 1;
         end
         if (expRv) void'(refQ.pop_front());
         if (memReq && expGnt) refQ.push_back(tgt);
         for (int j = 0; j < N; j++) begin
            if (slvRvalid[j]) begin
               slvPend[j]--;
               slvWait[j] = 0;
            end else if (slvPend[j] > 0) begin
               slvWait[j]++;
            end
            if (memReq && expGnt && tgt == j) slvPend[j]++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
